// File: rtl/mips_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// mips_multicycle_ctrl : multicycle MIPS control FSM with memory wait timeout
//                        and illegal-instruction trapping.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_ctrl #(
    parameter int WAIT_MAX        = 15,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rt,
    input  logic       i_cond,
    input  logic       i_mem_ack,
    output logic [5:0] o_alu_ctrl,
    output logic       o_reg_dst,
    output logic       o_alu_src,
    output logic       o_reg_write,
    output logic       o_mem_to_reg,
    output logic       o_mem_req,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic [1:0] o_size,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_instr_done,
    output logic       o_illegal,
    output logic       o_trap,
    output logic [2:0] o_state
);

    localparam int                WCNT_W       = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] C_WAIT_LIMIT = WCNT_W'(WAIT_MAX);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP     = 3'd0,
        CL_ALU_R   = 3'd1,
        CL_ALU_I   = 3'd2,
        CL_LOAD    = 3'd3,
        CL_STORE   = 3'd4,
        CL_BRANCH  = 3'd5,
        CL_JUMP    = 3'd6,
        CL_ILLEGAL = 3'd7
    } class_t;

    state_t            r_state;
    state_t            w_next;
    logic [WCNT_W-1:0] r_wait;
    class_t            w_class;
    logic [5:0]        w_alu;
    logic [1:0]        w_size;
    logic              w_alu_src;
    logic              w_mem_phase;
    logic              w_timeout;
    logic              w_count_en;
    logic              w_unused;

    assign w_unused = ^i_rt[4:1];

    // Instruction classification; alu/size are only meaningful for legal encodings.
    always_comb begin
        w_class = CL_ILLEGAL;
        w_alu   = 6'b000000;
        w_size  = 2'b00;
        case (i_opcode)
            6'h00: begin
                case (i_funct)
                    6'h00: w_class = CL_NOP;
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27: begin
                        w_class = CL_ALU_R;
                        w_alu   = {3'b100, i_funct[2:0]};
                    end
                    6'h2A: begin w_class = CL_ALU_R; w_alu = 6'b101000; end
                    6'h2B: begin w_class = CL_ALU_R; w_alu = 6'b101001; end
                    default: w_class = CL_ILLEGAL;
                endcase
            end
            6'h23: begin w_class = CL_LOAD;  w_alu = 6'b100000; w_size = 2'b11; end
            6'h20: begin w_class = CL_LOAD;  w_alu = 6'b100000; w_size = 2'b00; end
            6'h21: begin w_class = CL_LOAD;  w_alu = 6'b100000; w_size = 2'b01; end
            6'h24: begin w_class = CL_LOAD;  w_alu = 6'b100000; w_size = 2'b00; end
            6'h25: begin w_class = CL_LOAD;  w_alu = 6'b100000; w_size = 2'b01; end
            6'h2B: begin w_class = CL_STORE; w_alu = 6'b100000; w_size = 2'b11; end
            6'h28: begin w_class = CL_STORE; w_alu = 6'b100000; w_size = 2'b00; end
            6'h29: begin w_class = CL_STORE; w_alu = 6'b100000; w_size = 2'b01; end
            6'h08: begin w_class = CL_ALU_I; w_alu = 6'b100000; end
            6'h09: begin w_class = CL_ALU_I; w_alu = 6'b100001; end
            6'h0C: begin w_class = CL_ALU_I; w_alu = 6'b100100; end
            6'h0D: begin w_class = CL_ALU_I; w_alu = 6'b100101; end
            6'h0E: begin w_class = CL_ALU_I; w_alu = 6'b100110; end
            6'h04: begin w_class = CL_BRANCH; w_alu = 6'b111100; end
            6'h05: begin w_class = CL_BRANCH; w_alu = 6'b111101; end
            6'h06: begin w_class = CL_BRANCH; w_alu = 6'b111110; end
            6'h07: begin w_class = CL_BRANCH; w_alu = 6'b111111; end
            6'h01: begin w_class = CL_BRANCH; w_alu = {5'b11100, i_rt[0]}; end
            6'h02: begin w_class = CL_JUMP;   w_alu = 6'b111010; end
            default: w_class = CL_ILLEGAL;
        endcase
    end

    assign w_alu_src   = (w_class == CL_LOAD) || (w_class == CL_STORE) || (w_class == CL_ALU_I);
    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout   = w_mem_phase && !i_mem_ack && (r_wait == C_WAIT_LIMIT);
    assign w_count_en  = w_mem_phase && !i_mem_ack && !w_timeout;

    always_comb begin
        w_next       = r_state;
        o_alu_ctrl   = 6'b000000;
        o_reg_dst    = 1'b0;
        o_alu_src    = 1'b0;
        o_reg_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_size       = 2'b00;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_instr_done = 1'b0;
        o_illegal    = 1'b0;
        o_trap       = 1'b0;
        case (r_state)
            S_RST: w_next = S_FETCH;
            S_FETCH: begin
                o_mem_req  = 1'b1;
                o_mem_read = 1'b1;
                o_size     = 2'b11;
                if (i_mem_ack) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: begin
                o_alu_ctrl = w_alu;
                o_alu_src  = w_alu_src;
                if (w_class == CL_ILLEGAL) begin
                    if (TRAP_ON_ILLEGAL) begin
                        w_next = S_TRAP;
                    end else begin
                        o_illegal    = 1'b1;
                        o_instr_done = 1'b1;
                        w_next       = S_FETCH;
                    end
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                o_alu_ctrl = w_alu;
                o_alu_src  = w_alu_src;
                case (w_class)
                    CL_ALU_R, CL_ALU_I: w_next = S_WB;
                    CL_LOAD, CL_STORE:  w_next = S_MEM;
                    CL_BRANCH: begin
                        o_pc_write   = i_cond;
                        o_instr_done = 1'b1;
                        w_next       = S_FETCH;
                    end
                    CL_JUMP: begin
                        o_pc_write   = 1'b1;
                        o_instr_done = 1'b1;
                        w_next       = S_FETCH;
                    end
                    default: begin
                        o_instr_done = 1'b1;
                        w_next       = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                o_alu_ctrl  = w_alu;
                o_alu_src   = w_alu_src;
                o_mem_req   = 1'b1;
                o_mem_read  = (w_class == CL_LOAD);
                o_mem_write = (w_class == CL_STORE);
                o_size      = w_size;
                if (i_mem_ack) begin
                    if (w_class == CL_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        o_instr_done = 1'b1;
                        w_next       = S_FETCH;
                    end
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_WB: begin
                o_alu_ctrl   = w_alu;
                o_alu_src    = w_alu_src;
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
                o_mem_to_reg = (w_class == CL_LOAD);
                o_reg_dst    = (w_class == CL_ALU_R);
                w_next       = S_FETCH;
            end
            S_TRAP: begin
                o_trap = 1'b1;
                w_next = S_TRAP;
            end
            default: w_next = S_RST;
        endcase
    end

    assign o_state = r_state;

    // Counter idles at zero outside FETCH/MEM, so every request phase starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RST;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_count_en ? (r_wait + WCNT_W'(1)) : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// tb_mips_multicycle_ctrl : directed scoreboard bench for mips_multicycle_ctrl.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic [4:0] rt;
    logic       cond, mem_ack;

    // Flag order: reg_dst alu_src reg_write mem_to_reg mem_req mem_read mem_write ir_write pc_write instr_done illegal trap
    localparam logic [11:0] F_RDST = 12'h800, F_ASRC = 12'h400, F_RW   = 12'h200, F_M2R  = 12'h100;
    localparam logic [11:0] F_REQ  = 12'h080, F_MRD  = 12'h040, F_MWR  = 12'h020, F_IRW  = 12'h010;
    localparam logic [11:0] F_PCW  = 12'h008, F_DONE = 12'h004, F_ILL  = 12'h002, F_TRAP = 12'h001;
    localparam logic [11:0] F_NONE = 12'h000;

    logic [5:0] a_alu, b_alu;
    logic [1:0] a_size, b_size;
    logic [2:0] a_state, b_state;
    logic a_rdst, a_asrc, a_rw, a_m2r, a_req, a_mrd, a_mwr, a_irw, a_pcw, a_done, a_ill, a_trap;
    logic b_rdst, b_asrc, b_rw, b_m2r, b_req, b_mrd, b_mwr, b_irw, b_pcw, b_done, b_ill, b_trap;

    // DUT A: default parameters. DUT B: short timeout, illegal retires as NOP.
    mips_multicycle_ctrl #(.WAIT_MAX(15), .TRAP_ON_ILLEGAL(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_funct(funct), .i_rt(rt),
        .i_cond(cond), .i_mem_ack(mem_ack), .o_alu_ctrl(a_alu), .o_reg_dst(a_rdst),
        .o_alu_src(a_asrc), .o_reg_write(a_rw), .o_mem_to_reg(a_m2r), .o_mem_req(a_req),
        .o_mem_read(a_mrd), .o_mem_write(a_mwr), .o_size(a_size), .o_ir_write(a_irw),
        .o_pc_write(a_pcw), .o_instr_done(a_done), .o_illegal(a_ill), .o_trap(a_trap),
        .o_state(a_state)
    );

    mips_multicycle_ctrl #(.WAIT_MAX(3), .TRAP_ON_ILLEGAL(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_funct(funct), .i_rt(rt),
        .i_cond(cond), .i_mem_ack(mem_ack), .o_alu_ctrl(b_alu), .o_reg_dst(b_rdst),
        .o_alu_src(b_asrc), .o_reg_write(b_rw), .o_mem_to_reg(b_m2r), .o_mem_req(b_req),
        .o_mem_read(b_mrd), .o_mem_write(b_mwr), .o_size(b_size), .o_ir_write(b_irw),
        .o_pc_write(b_pcw), .o_instr_done(b_done), .o_illegal(b_ill), .o_trap(b_trap),
        .o_state(b_state)
    );

    always #5 clk = ~clk;

    logic [22:0] vec_a, vec_b;
    assign vec_a = {a_state, a_alu, a_size, a_rdst, a_asrc, a_rw, a_m2r, a_req, a_mrd,
                    a_mwr, a_irw, a_pcw, a_done, a_ill, a_trap};
    assign vec_b = {b_state, b_alu, b_size, b_rdst, b_asrc, b_rw, b_m2r, b_req, b_mrd,
                    b_mwr, b_irw, b_pcw, b_done, b_ill, b_trap};

    typedef struct {
        int          sel;
        string       tag;
        logic [22:0] exp;
    } exp_t;

    exp_t  sb[$];
    string tname = "init";
    int    n_cmp = 0;
    int    n_bad = 0;

    // Monitor: drains every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [22:0] act;
            e   = sb.pop_front();
            act = (e.sel == 1) ? vec_b : vec_a;
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s dut=%s got state=%0d alu=%b size=%b flags=%h, want state=%0d alu=%b size=%b flags=%h",
                         e.tag, (e.sel == 1) ? "B" : "A",
                         act[22:20], act[19:14], act[13:12], act[11:0],
                         e.exp[22:20], e.exp[19:14], e.exp[13:12], e.exp[11:0]);
            end
        end
    end

    task automatic cyc(input logic rstn, input logic c, input logic ack);
        @(posedge clk);
        #1;
        rst_n   = rstn;
        cond    = c;
        mem_ack = ack;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
        opcode = op;
        funct  = fn;
        rt     = r;
    endtask

    // sel: 0 = DUT A, 1 = DUT B, 2 = both
    task automatic chk(input int sel, input logic [2:0] st, input logic [5:0] alu,
                       input logic [1:0] sz, input logic [11:0] fl);
        exp_t e;
        e.tag = tname;
        e.exp = {st, alu, sz, fl};
        if (sel != 1) begin e.sel = 0; sb.push_back(e); end
        if (sel != 0) begin e.sel = 1; sb.push_back(e); end
    endtask

    // Immediate check of the settled outputs in the current cycle.
    task automatic chk_now(input int sel, input logic [2:0] st, input logic [5:0] alu,
                           input logic [1:0] sz, input logic [11:0] fl);
        logic [22:0] exp_v;
        logic [22:0] act;
        exp_v = {st, alu, sz, fl};
        #1;
        for (int k = 0; k < 2; k++) begin
            if ((sel == 2) || (sel == k)) begin
                act = (k == 1) ? vec_b : vec_a;
                n_cmp++;
                if (act !== exp_v) begin
                    n_bad++;
                    $display("FAIL(now) %s dut=%s got %h want %h",
                             tname, (k == 1) ? "B" : "A", act, exp_v);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cond = 1'b0; mem_ack = 1'b0;
        set_ir(6'h00, 6'h20, 5'd0);

        tname = "reset";
        cyc(0, 0, 1); chk(2, 3'd0, 6'b000000, 2'b00, F_NONE);
        chk_now(2, 3'd0, 6'b000000, 2'b00, F_NONE);
        cyc(1, 0, 1); chk(2, 3'd0, 6'b000000, 2'b00, F_NONE);

        tname = "add";
        cyc(1, 0, 1); chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD | F_IRW | F_PCW);
        cyc(1, 0, 1); chk(2, 3'd2, 6'b100000, 2'b00, F_NONE);
        cyc(1, 0, 1); chk(2, 3'd3, 6'b100000, 2'b00, F_NONE);
        cyc(1, 0, 1); chk(2, 3'd5, 6'b100000, 2'b00, F_RDST | F_RW | F_DONE);

        tname = "lh_wait2";
        cyc(1, 0, 1); set_ir(6'h21, 6'h00, 5'd0);
        chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD | F_IRW | F_PCW);
        cyc(1, 0, 1); chk(2, 3'd2, 6'b100000, 2'b00, F_ASRC);
        cyc(1, 0, 1); chk(2, 3'd3, 6'b100000, 2'b00, F_ASRC);
        cyc(1, 0, 0); chk(2, 3'd4, 6'b100000, 2'b01, F_ASRC | F_REQ | F_MRD);
        cyc(1, 0, 0); chk(2, 3'd4, 6'b100000, 2'b01, F_ASRC | F_REQ | F_MRD);
        cyc(1, 0, 1); chk(2, 3'd4, 6'b100000, 2'b01, F_ASRC | F_REQ | F_MRD);
        cyc(1, 0, 1); chk(2, 3'd5, 6'b100000, 2'b00, F_ASRC | F_RW | F_M2R | F_DONE);

        tname = "bltz_taken";
        cyc(1, 0, 1); set_ir(6'h01, 6'h00, 5'd0);
        chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD | F_IRW | F_PCW);
        cyc(1, 1, 1); chk(2, 3'd2, 6'b111000, 2'b00, F_NONE);
        cyc(1, 1, 1); chk(2, 3'd3, 6'b111000, 2'b00, F_PCW | F_DONE);

        tname = "bgez_not_taken";
        cyc(1, 0, 1); set_ir(6'h01, 6'h00, 5'd1);
        chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD | F_IRW | F_PCW);
        cyc(1, 0, 1); chk(2, 3'd2, 6'b111001, 2'b00, F_NONE);
        cyc(1, 0, 1); chk(2, 3'd3, 6'b111001, 2'b00, F_DONE);

        tname = "ori";
        cyc(1, 0, 1); set_ir(6'h0D, 6'h00, 5'd0);
        chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD | F_IRW | F_PCW);
        cyc(1, 0, 1); chk(2, 3'd2, 6'b100101, 2'b00, F_ASRC);
        cyc(1, 0, 1); chk(2, 3'd3, 6'b100101, 2'b00, F_ASRC);
        cyc(1, 0, 1); chk(2, 3'd5, 6'b100101, 2'b00, F_ASRC | F_RW | F_DONE);

        tname = "sw_reset";
        cyc(1, 0, 1); set_ir(6'h2B, 6'h00, 5'd0);
        chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD | F_IRW | F_PCW);
        cyc(1, 0, 1); chk(2, 3'd2, 6'b100000, 2'b00, F_ASRC);
        cyc(1, 0, 1); chk(2, 3'd3, 6'b100000, 2'b00, F_ASRC);
        cyc(1, 0, 0); chk(2, 3'd4, 6'b100000, 2'b11, F_ASRC | F_REQ | F_MWR);
        cyc(0, 0, 0); chk(2, 3'd0, 6'b000000, 2'b00, F_NONE);
        cyc(1, 0, 0); chk(2, 3'd0, 6'b000000, 2'b00, F_NONE);
        cyc(1, 0, 0); set_ir(6'h02, 6'h00, 5'd0);
        chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD);

        tname = "wait_exact";
        cyc(1, 0, 0); chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD);
        cyc(1, 0, 0); chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD);
        cyc(1, 0, 1); chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD | F_IRW | F_PCW);
        cyc(1, 0, 1); chk(2, 3'd2, 6'b111010, 2'b00, F_NONE);
        cyc(1, 0, 1); chk(2, 3'd3, 6'b111010, 2'b00, F_PCW | F_DONE);

        tname = "wait_timeout";
        cyc(1, 0, 0); chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD);
        cyc(1, 0, 0); chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD);
        cyc(1, 0, 0); chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD);
        cyc(1, 0, 0); chk(0, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD);
        cyc(1, 0, 1); chk(0, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD | F_IRW | F_PCW);
        chk(1, 3'd7, 6'b000000, 2'b00, F_TRAP);
        chk_now(1, 3'd7, 6'b000000, 2'b00, F_TRAP);
        cyc(1, 0, 1); chk(0, 3'd2, 6'b111010, 2'b00, F_NONE);
        chk(1, 3'd7, 6'b000000, 2'b00, F_TRAP);
        chk_now(1, 3'd7, 6'b000000, 2'b00, F_TRAP);

        tname = "illegal";
        cyc(0, 0, 1); chk(2, 3'd0, 6'b000000, 2'b00, F_NONE);
        cyc(1, 0, 1); set_ir(6'h3F, 6'h00, 5'd0);
        chk(2, 3'd0, 6'b000000, 2'b00, F_NONE);
        cyc(1, 0, 1); chk(2, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD | F_IRW | F_PCW);
        cyc(1, 0, 1); chk(0, 3'd2, 6'b000000, 2'b00, F_NONE);
        chk(1, 3'd2, 6'b000000, 2'b00, F_ILL | F_DONE);
        cyc(1, 0, 1); chk(0, 3'd7, 6'b000000, 2'b00, F_TRAP);
        chk(1, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD | F_IRW | F_PCW);

        tname = "nop";
        cyc(1, 0, 1); set_ir(6'h00, 6'h00, 5'd0);
        chk(0, 3'd7, 6'b000000, 2'b00, F_TRAP);
        chk(1, 3'd2, 6'b000000, 2'b00, F_NONE);
        cyc(1, 0, 1); chk(0, 3'd7, 6'b000000, 2'b00, F_TRAP);
        chk(1, 3'd3, 6'b000000, 2'b00, F_DONE);
        cyc(1, 0, 1); chk(0, 3'd7, 6'b000000, 2'b00, F_TRAP);
        chk(1, 3'd1, 6'b000000, 2'b11, F_REQ | F_MRD | F_IRW | F_PCW);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
